// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external 4-bit logical barrel shifter between two requesters.
// Define SHIFT_ARBITER_ROTATE_EN to build rotates from two logical passes (PASS_A then PASS_B).
package shift_arbiter_pkg;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned AMT_W  = 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
      logic              dir;
      logic              id;
   } job_t;
endpackage

module shift_arbiter
   import shift_arbiter_pkg::*;
#(
   parameter int unsigned FAIR = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [AMT_W-1:0]  req0_amt,
   input  logic              req0_dir,
   input  logic              req0_rot,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [AMT_W-1:0]  req1_amt,
   input  logic              req1_dir,
   input  logic              req1_rot,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic              busy,
   output logic [DATA_W-1:0] sh_din,
   output logic [AMT_W-1:0]  sh_amt,
   output logic              sh_dir,
   input  logic [DATA_W-1:0] sh_dout
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] PASS_A = 2'd1;
`ifdef SHIFT_ARBITER_ROTATE_EN
   localparam logic [1:0] PASS_B = 2'd2;
`endif
   localparam logic [1:0] RESP   = 2'd3;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   job_t              job_q;
   job_t              job_nxt;
   logic              last_grant;
   logic              last_grant_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_data_nxt;
   logic              rsp_id_nxt;
   logic              busy_nxt;
   logic [AMT_W-1:0]  sh_amt_nxt;
   logic              sh_dir_nxt;
   logic              grant_c;
   logic              accept_c;
   job_t              sel_c;

`ifdef SHIFT_ARBITER_ROTATE_EN
   logic              rot_q;
   logic              rot_nxt;
   logic              sel_rot_c;
   logic [DATA_W-1:0] part_q;
   logic [DATA_W-1:0] part_nxt;
`else
   logic              unused_rot;
   assign unused_rot = req0_rot ^ req1_rot;
`endif

   // Grant: lone requester wins; on a contest, round-robin or fixed req0 priority.
   always_comb begin
      grant_c = 1'b0;
      if (req0_valid && req1_valid)
         grant_c = (FAIR != 0) ? ~last_grant : 1'b0;
      else if (req1_valid)
         grant_c = 1'b1;
   end

   assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_c;
   assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  grant_c;
   assign accept_c   = req0_ready || req1_ready;

   always_comb begin
      sel_c.data = req0_data;
      sel_c.amt  = req0_amt;
      sel_c.dir  = req0_dir;
      sel_c.id   = 1'b0;
      if (grant_c) begin
         sel_c.data = req1_data;
         sel_c.amt  = req1_amt;
         sel_c.dir  = req1_dir;
         sel_c.id   = 1'b1;
      end
   end

`ifdef SHIFT_ARBITER_ROTATE_EN
   assign sel_rot_c = grant_c ? req1_rot : req0_rot;
`endif

   // Next-state and next values of every registered output.
   always_comb begin
      state_nxt      = state;
      job_nxt        = job_q;
      last_grant_nxt = last_grant;
      rsp_data_nxt   = rsp_data;
      rsp_id_nxt     = rsp_id;
`ifdef SHIFT_ARBITER_ROTATE_EN
      rot_nxt        = rot_q;
      part_nxt       = part_q;
`endif

      case (state)
         IDLE: begin
            if (accept_c) begin
               job_nxt        = sel_c;
               last_grant_nxt = grant_c;
`ifdef SHIFT_ARBITER_ROTATE_EN
               rot_nxt        = sel_rot_c;
`endif
               if (sel_c.amt == '0) begin
                  rsp_data_nxt = sel_c.data;
                  rsp_id_nxt   = sel_c.id;
                  state_nxt    = RESP;
               end else begin
                  state_nxt    = PASS_A;
               end
            end
         end
         PASS_A: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
            part_nxt = sh_dout;
            if (rot_q) begin
               state_nxt = PASS_B;
            end else begin
               rsp_data_nxt = sh_dout;
               rsp_id_nxt   = job_q.id;
               state_nxt    = RESP;
            end
`else
            rsp_data_nxt = sh_dout;
            rsp_id_nxt   = job_q.id;
            state_nxt    = RESP;
`endif
         end
`ifdef SHIFT_ARBITER_ROTATE_EN
         PASS_B: begin
            rsp_data_nxt = part_q | sh_dout;
            rsp_id_nxt   = job_q.id;
            state_nxt    = RESP;
         end
`endif
         RESP: begin
            if (rsp_ready)
               state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      rsp_valid_nxt = (state_nxt == RESP);
      busy_nxt      = (state_nxt != IDLE);

      // Shifter drive for the state being entered; parked at amount 0 otherwise.
      sh_amt_nxt = '0;
      sh_dir_nxt = job_nxt.dir;
      if (state_nxt == PASS_A)
         sh_amt_nxt = job_nxt.amt;
`ifdef SHIFT_ARBITER_ROTATE_EN
      if (state_nxt == PASS_B) begin
         sh_amt_nxt = ~job_nxt.amt + AMT_W'(1);
         sh_dir_nxt = ~job_nxt.dir;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         job_q      <= '0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         busy       <= 1'b0;
         sh_amt     <= '0;
         sh_dir     <= 1'b0;
`ifdef SHIFT_ARBITER_ROTATE_EN
         rot_q      <= 1'b0;
         part_q     <= '0;
`endif
      end else begin
         state      <= state_nxt;
         job_q      <= job_nxt;
         last_grant <= last_grant_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_data   <= rsp_data_nxt;
         rsp_id     <= rsp_id_nxt;
         busy       <= busy_nxt;
         sh_amt     <= sh_amt_nxt;
         sh_dir     <= sh_dir_nxt;
`ifdef SHIFT_ARBITER_ROTATE_EN
         rot_q      <= rot_nxt;
         part_q     <= part_nxt;
`endif
      end
   end

   assign sh_din = job_q.data;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: job-level timing/result model checked every cycle,
// plus directed vectors with literal expectations.
module tb_shift_arbiter;

`ifdef SHIFT_ARBITER_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [3:0] req0_data = 4'd0, req1_data = 4'd0;
   logic [1:0] req0_amt = 2'd0, req1_amt = 2'd0;
   logic       req0_dir = 1'b0, req1_dir = 1'b0;
   logic       req0_rot = 1'b0, req1_rot = 1'b0;
   logic       rsp_ready = 1'b1;

   logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy, sh_dir;
   logic [3:0] rsp_data, sh_din, sh_dout;
   logic [1:0] sh_amt;

   logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_busy, fp_sh_dir;
   logic [3:0] fp_rsp_data, fp_sh_din, fp_sh_dout;
   logic [1:0] fp_sh_amt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External combinational logical shifter, one per instance.
   assign sh_dout    = sh_dir ? (sh_din >> sh_amt) : (sh_din << sh_amt);
   assign fp_sh_dout = fp_sh_dir ? (fp_sh_din >> fp_sh_amt) : (fp_sh_din << fp_sh_amt);

   shift_arbiter #(.FAIR(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_dir(req0_dir), .req0_rot(req0_rot),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_dir(req1_dir), .req1_rot(req1_rot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .busy(busy), .sh_din(sh_din), .sh_amt(sh_amt), .sh_dir(sh_dir), .sh_dout(sh_dout)
   );

   shift_arbiter #(.FAIR(0)) u_dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_dir(req0_dir), .req0_rot(req0_rot),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_dir(req1_dir), .req1_rot(req1_rot),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data), .rsp_id(fp_rsp_id),
      .busy(fp_busy), .sh_din(fp_sh_din), .sh_amt(fp_sh_amt), .sh_dir(fp_sh_dir), .sh_dout(fp_sh_dout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job-level model: result by rotate/shift arithmetic, latency by pass count.
   bit         m_resp;
   int         m_left, m_passes;
   logic [3:0] m_res, m_data;
   logic [1:0] m_amt;
   logic       m_dir, m_id, m_last;
   bit         log_en = 1'b0;
   int         dut_log[$];
   int         fp_log[$];

   function automatic logic [3:0] expect_result(input logic [3:0] d, input logic [1:0] k,
                                                input logic dir, input logic rot);
      logic [7:0] wide;
      int kk;
      kk = int'(k);
      wide = {d, d};
      if (kk == 0) return d;
      if (rot && ROT) return dir ? wide[kk +: 4] : wide[(4 - kk) +: 4];
      return dir ? (d >> kk) : 4'(d << kk);
   endfunction

   function automatic logic pick(input logic v0, input logic v1);
      return (v0 && v1) ? ~m_last : v1;
   endfunction

   task automatic model_reset();
      m_resp = 1'b0; m_left = 0; m_passes = 0; m_res = 4'd0; m_data = 4'd0;
      m_amt = 2'd0; m_dir = 1'b0; m_id = 1'b0; m_last = 1'b1;
   endtask

   task automatic model_step();
      logic g, rot;
      if (m_resp) begin
         if (rsp_ready) m_resp = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) m_resp = 1'b1;
      end else if (req0_valid || req1_valid) begin
         g      = pick(req0_valid, req1_valid);
         m_last = g;
         m_id   = g;
         m_data = g ? req1_data : req0_data;
         m_amt  = g ? req1_amt : req0_amt;
         m_dir  = g ? req1_dir : req0_dir;
         rot    = g ? req1_rot : req0_rot;
         m_res  = expect_result(m_data, m_amt, m_dir, rot);
         m_passes = (m_amt == 2'd0) ? 0 : ((rot && ROT) ? 2 : 1);
         m_left = m_passes;
         m_resp = (m_passes == 0);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial begin
      bit         idle;
      logic       g;
      int         pass;
      logic [1:0] exp_amt;
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
            chk("rst_ready0", req0_ready, 0);
            chk("rst_ready1", req1_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_sh_amt", sh_amt, 0);
            chk("rst_sh_din", sh_din, 0);
            chk("rst_sh_dir", sh_dir, 0);
         end else begin
            idle = !m_resp && (m_left == 0);
            g = pick(req0_valid, req1_valid);
            chk("ready0", req0_ready, idle && req0_valid && !g);
            chk("ready1", req1_ready, idle && req1_valid && g);
            chk("busy", busy, !idle);
            chk("rsp_valid", rsp_valid, m_resp);
            if (m_resp) begin
               chk("rsp_data", rsp_data, m_res);
               chk("rsp_id", rsp_id, m_id);
            end
            pass = (idle || m_resp) ? 0 : (m_passes - m_left + 1);
            exp_amt = (pass == 1) ? m_amt : (pass == 2) ? 2'(4 - int'(m_amt)) : 2'd0;
            chk("sh_amt", sh_amt, exp_amt);
            chk("sh_dir", sh_dir, (pass == 2) ? ~m_dir : m_dir);
            chk("sh_din", sh_din, m_data);
            if (log_en) begin
               if (req0_valid && req0_ready) dut_log.push_back(0);
               if (req1_valid && req1_ready) dut_log.push_back(1);
               if (req0_valid && fp_req0_ready) fp_log.push_back(0);
               if (req1_valid && fp_req1_ready) fp_log.push_back(1);
            end
            model_step();
         end
      end
   end

   task automatic send(input bit who, input logic [3:0] d, input logic [1:0] k,
                       input logic dir, input logic rot, output int t_acc);
      @(posedge clk); #1;
      if (who) begin
         req1_data = d; req1_amt = k; req1_dir = dir; req1_rot = rot; req1_valid = 1'b1;
      end else begin
         req0_data = d; req0_amt = k; req0_dir = dir; req0_rot = rot; req0_valid = 1'b1;
      end
      t_acc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (who ? req1_ready : req0_ready) begin
            t_acc = cyc;
            break;
         end
      end
      chk("accept_seen", t_acc >= 0, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int t_rsp);
      t_rsp = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            t_rsp = cyc;
            break;
         end
      end
      chk("rsp_seen", t_rsp >= 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t, tr, done;
      int exp_fair[4];
      exp_fair = '{0, 1, 0, 1};

      // Contest from reset: both requesters valid throughout.
      req0_data = 4'b1011; req0_amt = 2'd1; req0_dir = 1'b0; req0_rot = 1'b0;
      req1_data = 4'b0011; req1_amt = 2'd1; req1_dir = 1'b1; req1_rot = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1; log_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 60 && dut_log.size() < 4; i++) @(negedge clk);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; log_en = 1'b0;
      chk("fair_count", dut_log.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < dut_log.size()) chk("fair_order", dut_log[i], exp_fair[i]);
      chk("fixed_count_ge3", fp_log.size() >= 3, 1);
      for (int i = 0; i < 3; i++)
         if (i < fp_log.size()) chk("fixed_order", fp_log[i], 0);
      done = 0;
      for (int i = 0; i < 20 && done == 0; i++) begin
         @(negedge clk);
         if (!busy && !fp_busy) done = 1;
      end
      chk("drain_idle", done, 1);

      // req0 shift left 2: 1011 -> 1100 in two cycles.
      send(1'b0, 4'b1011, 2'd2, 1'b0, 1'b0, t);
      @(negedge clk);
      chk("A_pass_amt", sh_amt, 2);
      chk("A_pass_dir", sh_dir, 0);
      chk("A_pass_dout", sh_dout, 4'b1100);
      wait_rsp(tr);
      chk("A_latency", tr - t, 2);
      chk("A_data", rsp_data, 4'b1100);
      chk("A_id", rsp_id, 0);

      // req1 rotate right 1 of 1011.
      send(1'b1, 4'b1011, 2'd1, 1'b1, 1'b1, t);
      @(negedge clk);
      chk("B_passa_amt", sh_amt, 1);
      chk("B_passa_dir", sh_dir, 1);
      chk("B_passa_dout", sh_dout, 4'b0101);
      chk("B_passa_valid", rsp_valid, 0);
`ifdef SHIFT_ARBITER_ROTATE_EN
      @(negedge clk);
      chk("B_passb_amt", sh_amt, 3);
      chk("B_passb_dir", sh_dir, 0);
      chk("B_passb_dout", sh_dout, 4'b1000);
      chk("B_passb_valid", rsp_valid, 0);
      wait_rsp(tr);
      chk("B_latency", tr - t, 3);
      chk("B_data", rsp_data, 4'b1101);
`else
      wait_rsp(tr);
      chk("B_latency", tr - t, 2);
      chk("B_data", rsp_data, 4'b0101);
`endif
      chk("B_id", rsp_id, 1);

      // Rotate with k=0 bypasses the shifter.
      send(1'b0, 4'b0110, 2'd0, 1'b1, 1'b1, t);
      @(negedge clk);
      chk("C_latency", cyc - t, 1);
      chk("C_valid", rsp_valid, 1);
      chk("C_sh_amt", sh_amt, 0);
      chk("C_data", rsp_data, 4'b0110);
      chk("C_id", rsp_id, 0);

      // Response stalled with a competing request pending.
      @(posedge clk); #1 rsp_ready = 1'b0;
      send(1'b1, 4'b1001, 2'd3, 1'b0, 1'b0, t);
      wait_rsp(tr);
      chk("D_latency", tr - t, 2);
      @(posedge clk); #1;
      req0_data = 4'b0001; req0_amt = 2'd1; req0_dir = 1'b0; req0_rot = 1'b0; req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("D_stall_valid", rsp_valid, 1);
         chk("D_stall_data", rsp_data, 4'b1000);
         chk("D_stall_id", rsp_id, 1);
         chk("D_stall_ready0", req0_ready, 0);
         chk("D_stall_ready1", req1_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("D_hs_valid", rsp_valid, 1);
      @(negedge clk);
      chk("D_next_ready0", req0_ready, 1);
      t = cyc;
      @(posedge clk); #1 req0_valid = 1'b0;
      wait_rsp(tr);
      chk("D_next_latency", tr - t, 2);
      chk("D_next_data", rsp_data, 4'b0010);
      chk("D_next_id", rsp_id, 0);

      // Reset pulse in the middle of a rotate job.
      send(1'b1, 4'b0110, 2'd1, 1'b1, 1'b1, t);
`ifdef SHIFT_ARBITER_ROTATE_EN
      @(posedge clk); #1;
      chk("E_in_passb_amt", sh_amt, 3);
`endif
      chk("E_busy_before", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("E_async_busy", busy, 0);
      chk("E_async_sh_amt", sh_amt, 0);
      chk("E_async_sh_din", sh_din, 0);
      chk("E_async_sh_dir", sh_dir, 0);
      chk("E_async_rsp_valid", rsp_valid, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("E_no_rsp", rsp_valid, 0);
         chk("E_idle", busy, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
